tile_scroll_addr_gen: RTL and testbench
=======================================

Name: tile_scroll_addr_gen

Overview:
- Upstream companion of the CUS43 dual tilemap generator.
- Holds the CPU-written X/Y scroll registers for tile layers A and B and runs the horizontal pixel counter.
- Each 8-pixel tile slot, generates time-multiplexed tilemap VRAM addresses and the HA2/HB2 latch strobes that CUS43 uses to capture tile data per layer.
- Also supplies fine-scroll and tile-row bits for graphics ROM addressing.

Parameters:
- H_TOTAL, 384: pixel clocks per line; the H counter wraps at H_TOTAL-1.
- LOOKAHEAD, 8: pixels of fetch lead, so data reaches CUS43 one tile ahead of display.

Ports:
- CLK_6M  in  1  pixel clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- H_START  in  1  one-cycle pulse; forces the H counter to 0 on the next edge.
- V  in  8  current scanline from the video timing block.
- FLIP  in  1  screen flip.
- CPU_CS  in  1  register select.
- CPU_WE  in  1  write strobe; a write occurs when CPU_CS & CPU_WE at an edge.
- CPU_A  in  3  register address.
- CPU_D  in  8  write data.
- VA  out  13  VRAM address: {layer, row[4:0], col[5:0], byte}.
- LAYER  out  1  0 = A slot, 1 = B slot.
- CPU_SLOT  out  1  high during phases 4-7; VRAM is free for CPU access.
- HA2  out  1  layer A latch strobe to CUS43.
- HB2  out  1  layer B latch strobe to CUS43.
- FINE_A  out  3  effective X[2:0] for layer A.
- FINE_B  out  3  effective X[2:0] for layer B.
- ROW_A  out  3  effective Y[2:0] for layer A.
- ROW_B  out  3  effective Y[2:0] for layer B.

Behaviour:
- Reset:
  - H counter = 0; all scroll registers (shadow and active) = 0.
  - VA = 0, LAYER = 0, CPU_SLOT = 0, HA2 = HB2 = 0, FINE_* = 0, ROW_* = 0.
- H counter: 9 bits; increments each clock; goes to 0 after H_TOTAL-1 or on H_START. H_START wins over the increment.
- Register map (writes go to shadow registers):
  - 0: XA[8] (bit 0); 1: XA[7:0]; 2: YA[7:0].
  - 4: XB[8]; 5: XB[7:0]; 6: YB[7:0].
  - 3 and 7: writes ignored.
- Shadow-to-active copy: on every line start (counter wrap or H_START).
  - A CPU write in the same cycle as a line start is included in the copy (write-through).
  - Mid-line writes never affect the current line.
- Effective coordinates, per layer L:
  - hx = FLIP ? (H_TOTAL-1-H-LOOKAHEAD) : (H+LOOKAHEAD).
  - x = (hx + XL) mod 512.
  - vy = FLIP ? 255-V : V.
  - y = (vy + YL) mod 256.
  - col = x[8:3]; row = y[7:3].
- Slot schedule, with phase = H[2:0] of the counter:
  - 0: A byte0 (tile code).
  - 1: A byte1 (attribute).
  - 2: B byte0.
  - 3: B byte1.
  - 4-7: CPU slot; VA holds its last value.
- Outputs are registered with latency 1: output values at edge t+1 reflect counter value at edge t.
  - VA = {LAYER, row, col, phase[0]}.
- Strobes:
  - HA2 = 1 exactly when the registered phase is 2; HB2 = 1 exactly when it is 4; each is one cycle wide.
  - CUS43 latches while the strobe is high and loads on its falling edge.
- FINE_* and ROW_*: updated at the phase-0 output and held for the whole slot.
- Reset mid-line: all state cleared on the same edge; the first post-reset A fetch appears at the output one cycle after counter = 0.
- X wrap: 511 → 0 is seamless. Y wrap: 255 → 0 is seamless.

Decomposition:
- Shared package:
  - H_TOTAL and LOOKAHEAD defaults.
  - Register address constants (REG_XA_HI … REG_YB).
  - Phase constants (PH_A0, PH_A1, PH_B0, PH_B1).
  - Layer encoding.
- One sub-module, tile_scroll_regs:
  - Shadow and active scroll register file with the CPU decode and line-start transfer.
  - Outputs the active XA/YA/XB/YB.
- Counter, coordinate arithmetic and slot sequencer stay in the top module.

Test Plan:
- Reset, then all scrolls 0, V=0, FLIP=0, pulse H_START → outputs after counter 0..3 give VA = 0x002, 0x003, 0x1002, 0x1003; HA2 high one cycle at phase 2, HB2 at phase 4; CPU_SLOT high at phases 4-7.
- Write reg0=1, reg1=0xF9 (XA=505), next line, H=0 → x = 513 mod 512 = 1, VA(A byte0) = 0x000, FINE_A = 1.
- Write reg2=0x0F, V=0x10 → y = 0x1F, VA(A byte0) at H=0 = 0x182, ROW_A = 7.
- FLIP=1, scrolls 0, V=0, H=0 → hx=375, col 46, row 31; VA(A byte0) = 0xFDC, FINE_A = 7.
- Write reg5=0x40 at H=100 → layer B addresses unchanged for the rest of the line, shifted by col+8 after the next H_START; a write coinciding with H_START takes effect on that same line.
- Assert RST at H=200 with non-zero scrolls → next edge: all outputs 0, scrolls 0, counter restarts at 0.

Source files
------------

// File: rtl/tile_scroll_addr_gen_pkg.sv
// Shared constants and types for the tilemap scroll / VRAM address generator.
package tile_scroll_addr_gen_pkg;

  localparam int H_TOTAL_DEF   = 384;
  localparam int LOOKAHEAD_DEF = 8;
  localparam int NUM_LAYERS    = 2;

  localparam logic [2:0] REG_XA_HI = 3'd0;
  localparam logic [2:0] REG_XA_LO = 3'd1;
  localparam logic [2:0] REG_YA    = 3'd2;
  localparam logic [2:0] REG_XB_HI = 3'd4;
  localparam logic [2:0] REG_XB_LO = 3'd5;
  localparam logic [2:0] REG_YB    = 3'd6;

  localparam logic [2:0] PH_A0 = 3'd0;
  localparam logic [2:0] PH_A1 = 3'd1;
  localparam logic [2:0] PH_B0 = 3'd2;
  localparam logic [2:0] PH_B1 = 3'd3;

  // Strobes fire one slot after the layer's fetch pair completes
  localparam logic [2:0] PH_HA2 = 3'd2;
  localparam logic [2:0] PH_HB2 = 3'd4;

  typedef enum logic { LAYER_A = 1'b0, LAYER_B = 1'b1 } layer_e;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } scroll_t;

endpackage

// File: rtl/tile_scroll_addr_gen_if.sv
// CPU register-write bus into the scroll address generator.
interface tile_scroll_addr_gen_if;
  logic       CPU_CS;
  logic       CPU_WE;
  logic [2:0] CPU_A;
  logic [7:0] CPU_D;

  modport master (output CPU_CS, CPU_WE, CPU_A, CPU_D);
  modport slave  (input  CPU_CS, CPU_WE, CPU_A, CPU_D);
endinterface

// File: rtl/tile_scroll_regs.sv
// Shadow/active scroll registers; shadow takes CPU writes, active reloads at line start.
module tile_scroll_regs
  import tile_scroll_addr_gen_pkg::*;
(
  input  logic                         CLK_6M,
  input  logic                         RST,
  input  logic                         line_start,
  tile_scroll_addr_gen_if.slave        cpu,
  output scroll_t                      scr_a,
  output scroll_t                      scr_b
);

  scroll_t sh_a, sh_b, nx_a, nx_b;

  always_comb begin
    nx_a = sh_a;
    nx_b = sh_b;
    if (cpu.CPU_CS && cpu.CPU_WE) begin
      case (cpu.CPU_A)
        REG_XA_HI: nx_a.x[8]   = cpu.CPU_D[0];
        REG_XA_LO: nx_a.x[7:0] = cpu.CPU_D;
        REG_YA:    nx_a.y      = cpu.CPU_D;
        REG_XB_HI: nx_b.x[8]   = cpu.CPU_D[0];
        REG_XB_LO: nx_b.x[7:0] = cpu.CPU_D;
        REG_YB:    nx_b.y      = cpu.CPU_D;
        default: ;
      endcase
    end
  end

  // Active copy takes the post-write shadow so a write on the line-start edge lands this line
  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      sh_a  <= '0;
      sh_b  <= '0;
      scr_a <= '0;
      scr_b <= '0;
    end else begin
      sh_a <= nx_a;
      sh_b <= nx_b;
      if (line_start) begin
        scr_a <= nx_a;
        scr_b <= nx_b;
      end
    end
  end

endmodule

// File: rtl/tile_scroll_addr_gen.sv
// H counter, per-layer scrolled coordinates and the 8-pixel VRAM fetch/strobe sequencer.
module tile_scroll_addr_gen
  import tile_scroll_addr_gen_pkg::*;
#(
  parameter int H_TOTAL   = H_TOTAL_DEF,
  parameter int LOOKAHEAD = LOOKAHEAD_DEF
) (
  input  logic                  CLK_6M,
  input  logic                  RST,
  input  logic                  H_START,
  input  logic [7:0]            V,
  input  logic                  FLIP,
  tile_scroll_addr_gen_if.slave cpu,
  output logic [12:0]           VA,
  output logic                  LAYER,
  output logic                  CPU_SLOT,
  output logic                  HA2,
  output logic                  HB2,
  output logic [2:0]            FINE_A,
  output logic [2:0]            FINE_B,
  output logic [2:0]            ROW_A,
  output logic [2:0]            ROW_B
);

  localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_LEAD    = 9'(LOOKAHEAD);
  localparam logic [8:0] H_FLIP_HX = 9'(H_TOTAL - 1 - LOOKAHEAD);

  logic [8:0] h;
  logic       line_start;

  assign line_start = H_START | (h == H_LAST);

  always_ff @(posedge CLK_6M) begin
    if (RST)             h <= '0;
    else if (line_start) h <= '0;
    else                 h <= h + 9'd1;
  end

  scroll_t scr_a, scr_b;

  tile_scroll_regs u_regs (
    .CLK_6M     (CLK_6M),
    .RST        (RST),
    .line_start (line_start),
    .cpu        (cpu),
    .scr_a      (scr_a),
    .scr_b      (scr_b)
  );

  // Modulo-512 / modulo-256 wrap falls out of the fixed widths
  logic [8:0] hx;
  logic [7:0] vy;
  assign hx = FLIP ? (H_FLIP_HX - h) : (h + H_LEAD);
  assign vy = FLIP ? ~V : V;

  logic [NUM_LAYERS-1:0][8:0] scr_x, eff_x;
  logic [NUM_LAYERS-1:0][7:0] scr_y, eff_y;
  assign scr_x = {scr_b.x, scr_a.x};
  assign scr_y = {scr_b.y, scr_a.y};

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    assign eff_x[l] = hx + scr_x[l];
    assign eff_y[l] = vy + scr_y[l];
  end

  logic [2:0]  phase;
  layer_e      sel;
  logic        fetch;
  logic [12:0] va_nx;

  assign phase = h[2:0];
  assign sel   = layer_e'(phase[1]);
  assign fetch = ~phase[2];
  assign va_nx = {sel, eff_y[sel][7:3], eff_x[sel][8:3], phase[0]};

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      VA       <= '0;
      LAYER    <= LAYER_A;
      CPU_SLOT <= 1'b0;
      HA2      <= 1'b0;
      HB2      <= 1'b0;
      FINE_A   <= '0;
      FINE_B   <= '0;
      ROW_A    <= '0;
      ROW_B    <= '0;
    end else begin
      HA2      <= (phase == PH_HA2);
      HB2      <= (phase == PH_HB2);
      CPU_SLOT <= phase[2];
      if (fetch) begin
        VA    <= va_nx;
        LAYER <= sel;
      end
      if (phase == PH_A0) begin
        FINE_A <= eff_x[LAYER_A][2:0];
        FINE_B <= eff_x[LAYER_B][2:0];
        ROW_A  <= eff_y[LAYER_A][2:0];
        ROW_B  <= eff_y[LAYER_B][2:0];
      end
    end
  end

endmodule

// File: tb/tb_tile_scroll_addr_gen.sv
// Directed bench for tile_scroll_addr_gen: fetch schedule, scroll math, flip, line-start copy, reset.
module tb_tile_scroll_addr_gen;

  logic        CLK_6M = 1'b0;
  logic        RST, H_START, FLIP;
  logic [7:0]  V;
  logic [12:0] VA;
  logic        LAYER, CPU_SLOT, HA2, HB2;
  logic [2:0]  FINE_A, FINE_B, ROW_A, ROW_B;

  int checks = 0;
  int errors = 0;

  tile_scroll_addr_gen_if bus ();

  tile_scroll_addr_gen dut (
    .CLK_6M   (CLK_6M),
    .RST      (RST),
    .H_START  (H_START),
    .V        (V),
    .FLIP     (FLIP),
    .cpu      (bus),
    .VA       (VA),
    .LAYER    (LAYER),
    .CPU_SLOT (CPU_SLOT),
    .HA2      (HA2),
    .HB2      (HB2),
    .FINE_A   (FINE_A),
    .FINE_B   (FINE_B),
    .ROW_A    (ROW_A),
    .ROW_B    (ROW_B)
  );

  always #5 CLK_6M = ~CLK_6M;

  task automatic tick();
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    bus.CPU_CS = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_A = a; bus.CPU_D = d;
    tick();
    bus.CPU_CS = 1'b0; bus.CPU_WE = 1'b0;
  endtask

  // After this returns the counter holds 0
  task automatic pulse_hstart();
    H_START = 1'b1;
    tick();
    H_START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ticks(2);
    checks++; if (VA !== 13'h000) begin errors++; $display("FAIL reset_va got %h want 000", VA); end
    checks++; if ({LAYER, CPU_SLOT, HA2, HB2} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b want 0000", {LAYER, CPU_SLOT, HA2, HB2}); end
    checks++; if ({FINE_A, FINE_B, ROW_A, ROW_B} !== 12'h000) begin errors++; $display("FAIL reset_fine_row got %h want 000", {FINE_A, FINE_B, ROW_A, ROW_B}); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    logic [12:0] exp_va;
    pulse_hstart();
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_va = (k == 0) ? 13'h002 : (k == 1) ? 13'h003 : (k == 2) ? 13'h1002 : 13'h1003;
      checks++; if (VA !== exp_va) begin errors++; $display("FAIL basic_va ph%0d got %h want %h", k, VA, exp_va); end
      checks++; if (HA2 !== (k == 2)) begin errors++; $display("FAIL basic_ha2 ph%0d got %b", k, HA2); end
      checks++; if (HB2 !== (k == 4)) begin errors++; $display("FAIL basic_hb2 ph%0d got %b", k, HB2); end
      checks++; if (CPU_SLOT !== (k >= 4)) begin errors++; $display("FAIL basic_cpu_slot ph%0d got %b", k, CPU_SLOT); end
      checks++; if (LAYER !== (k >= 2)) begin errors++; $display("FAIL basic_layer ph%0d got %b", k, LAYER); end
    end
  endtask

  task automatic test_xwrap();
    cpu_write(3'd0, 8'h01);
    cpu_write(3'd1, 8'hF9);
    pulse_hstart();
    tick();
    checks++; if (VA !== 13'h000) begin errors++; $display("FAIL xwrap_va got %h want 000", VA); end
    checks++; if (FINE_A !== 3'd1) begin errors++; $display("FAIL xwrap_fine_a got %0d want 1", FINE_A); end
    checks++; if (FINE_B !== 3'd0) begin errors++; $display("FAIL xwrap_fine_b got %0d want 0", FINE_B); end
    ticks(2);
    checks++; if (VA !== 13'h1002) begin errors++; $display("FAIL xwrap_b_va got %h want 1002", VA); end
    cpu_write(3'd0, 8'h00);
    cpu_write(3'd1, 8'h00);
  endtask

  task automatic test_yscroll();
    cpu_write(3'd2, 8'h0F);
    V = 8'h10;
    pulse_hstart();
    tick();
    checks++; if (VA !== 13'h182) begin errors++; $display("FAIL yscroll_va got %h want 182", VA); end
    checks++; if (ROW_A !== 3'd7) begin errors++; $display("FAIL yscroll_row_a got %0d want 7", ROW_A); end
    checks++; if (ROW_B !== 3'd0) begin errors++; $display("FAIL yscroll_row_b got %0d want 0", ROW_B); end
    // 0x20 + 0xF0 wraps to 0x10
    cpu_write(3'd2, 8'hF0);
    V = 8'h20;
    pulse_hstart();
    tick();
    checks++; if (VA !== 13'h102) begin errors++; $display("FAIL ywrap_va got %h want 102", VA); end
    checks++; if (ROW_A !== 3'd0) begin errors++; $display("FAIL ywrap_row_a got %0d want 0", ROW_A); end
    cpu_write(3'd2, 8'h00);
    V = 8'h00;
  endtask

  task automatic test_flip();
    FLIP = 1'b1;
    pulse_hstart();
    tick();
    checks++; if (VA !== 13'hFDC) begin errors++; $display("FAIL flip_va got %h want fdc", VA); end
    checks++; if (FINE_A !== 3'd7) begin errors++; $display("FAIL flip_fine_a got %0d want 7", FINE_A); end
    checks++; if (ROW_A !== 3'd7) begin errors++; $display("FAIL flip_row_a got %0d want 7", ROW_A); end
    FLIP = 1'b0;
  endtask

  task automatic test_midline_write();
    pulse_hstart();
    ticks(100);
    cpu_write(3'd5, 8'h40);
    ticks(6);
    checks++; if (VA !== 13'h101C) begin errors++; $display("FAIL midline_same_line_va got %h want 101c", VA); end
    pulse_hstart();
    ticks(3);
    checks++; if (VA !== 13'h1012) begin errors++; $display("FAIL midline_next_line_va got %h want 1012", VA); end
  endtask

  task automatic test_write_through();
    bus.CPU_CS = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_A = 3'd5; bus.CPU_D = 8'h80;
    H_START = 1'b1;
    tick();
    bus.CPU_CS = 1'b0; bus.CPU_WE = 1'b0; H_START = 1'b0;
    ticks(3);
    checks++; if (VA !== 13'h1022) begin errors++; $display("FAIL write_through_va got %h want 1022", VA); end
  endtask

  task automatic test_wrap();
    pulse_hstart();
    cpu_write(3'd6, 8'h05);
    ticks(8);
    checks++; if (ROW_B !== 3'd0) begin errors++; $display("FAIL wrap_row_b_before got %0d want 0", ROW_B); end
    checks++; if (VA !== 13'h004) begin errors++; $display("FAIL wrap_va_h8 got %h want 004", VA); end
    ticks(376);
    checks++; if (ROW_B !== 3'd5) begin errors++; $display("FAIL wrap_row_b_after got %0d want 5", ROW_B); end
    checks++; if (VA !== 13'h002) begin errors++; $display("FAIL wrap_va_h0 got %h want 002", VA); end
  endtask

  task automatic test_reset_midline();
    V = 8'h03;
    pulse_hstart();
    ticks(200);
    checks++; if (ROW_A !== 3'd3) begin errors++; $display("FAIL rstmid_pre_row_a got %0d want 3", ROW_A); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (VA !== 13'h000) begin errors++; $display("FAIL rstmid_va got %h want 000", VA); end
    checks++; if ({LAYER, CPU_SLOT, HA2, HB2} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctl got %b want 0000", {LAYER, CPU_SLOT, HA2, HB2}); end
    checks++; if ({FINE_A, FINE_B, ROW_A, ROW_B} !== 12'h000) begin errors++; $display("FAIL rstmid_fine_row got %h want 000", {FINE_A, FINE_B, ROW_A, ROW_B}); end
    tick();
    checks++; if (VA !== 13'h002) begin errors++; $display("FAIL rstmid_first_fetch got %h want 002", VA); end
    checks++; if (ROW_B !== 3'd3) begin errors++; $display("FAIL rstmid_row_b got %0d want 3", ROW_B); end
    ticks(2);
    checks++; if (VA !== 13'h1002) begin errors++; $display("FAIL rstmid_b_va got %h want 1002", VA); end
    checks++; if (HA2 !== 1'b1) begin errors++; $display("FAIL rstmid_ha2 got %b want 1", HA2); end
    V = 8'h00;
  endtask

  initial begin
    RST = 1'b1; H_START = 1'b0; FLIP = 1'b0; V = 8'h00;
    bus.CPU_CS = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_A = 3'd0; bus.CPU_D = 8'h00;
    test_reset();
    test_basic();
    test_xwrap();
    test_yscroll();
    test_flip();
    test_midline_write();
    test_write_through();
    test_wrap();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
